// File: rtl/bit_serial_adder_ctrl.sv
// bit_serial_adder_ctrl
// Bit-serial WIDTH-bit adder: one propagate/generate/sum slice is reused
// once per clock, LSB first. The block owns the operand shift registers,
// the carry flop, the bit counter and a start/busy/done handshake.
// A result takes WIDTH edges after the accepting edge. It is then held
// on sum/cout until the next completion.
// Optional build macro BSA_OVERFLOW_EN adds a registered two's-complement
// overflow output (ovf).
module bit_serial_adder_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef BSA_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             cout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic             c_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;
`ifdef BSA_OVERFLOW_EN
    logic             ovf_q;
`endif

    logic             slice_p;
    logic             slice_g;
    logic             slice_s;
    logic             carry_d;
    logic [WIDTH-1:0] acc_d;
    logic             last_bit;

    // Single-bit adder slice on the current LSBs, plus the accumulator shift.
    always_comb begin
        // NOTE: every signal written here is given a value on every path, so no latch is inferred.
        slice_p  = a_sh_q[0] ^ b_sh_q[0];
        slice_g  = a_sh_q[0] & b_sh_q[0];
        slice_s  = slice_p ^ c_q;
        carry_d  = slice_g | (slice_p & c_q);
        acc_d    = (acc_q >> 1) | {slice_s, {(WIDTH-1){1'b0}}};
        last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Sequencer and datapath registers. Every output is driven from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef BSA_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments make every flop here update from pre-edge values.
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        c_q     <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        // Abort wins over bit processing, even on the final bit.
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        c_q    <= carry_d;
                        acc_q  <= acc_d;
                        a_sh_q <= a_sh_q >> 1;
                        b_sh_q <= b_sh_q >> 1;
                        cnt_q  <= cnt_q + CNT_W'(1);
                        if (last_bit) begin
                            sum_q   <= acc_d;
                            cout_q  <= carry_d;
`ifdef BSA_OVERFLOW_EN
                            // c_q is the carry into the MSB; carry_d is the carry out of it.
                            ovf_q   <= c_q ^ carry_d;
`endif
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_DONE;
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef BSA_OVERFLOW_EN
    assign ovf  = ovf_q;
`endif

endmodule
